fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: instruction-memory handshake, datapath handoff and status.
// The master modport is the controller side; slave is the memory/datapath side.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [31:0] next_pc;
  logic        halt_req;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_pc;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, pc, instr, instr_valid, halted, fault, fault_code, fault_pc,
           retired,
    input  imem_ack, imem_rdata, exec_done, next_pc, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, pc, instr, instr_valid, halted, fault, fault_code, fault_pc,
           retired,
    output imem_ack, imem_rdata, exec_done, next_pc, halt_req
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: FETCH/EXEC sequencing with fetch timeout,
// misaligned next-PC detection and terminal HALT/FAULT states.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt, StFault} state_e;

  localparam logic [7:0] WaitMax = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic [7:0]  wait_q;
  logic [1:0]  fault_code_q;
  logic [31:0] fault_pc_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;
  logic        fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      retired_q    <= '0;
      wait_q       <= '0;
      fault_code_q <= 2'b00;
      fault_pc_q   <= '0;
      req_q        <= 1'b1;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            wait_q  <= '0;
            state_q <= StExec;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else if (wait_q == WaitMax) begin
            state_q      <= StFault;
            fault_code_q <= 2'b10;
            fault_pc_q   <= pc_q;
            req_q        <= 1'b0;
            fault_q      <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StExec: begin
          if (bus.exec_done) begin
            retired_q <= retired_q + 32'd1;
            valid_q   <= 1'b0;
            if (bus.halt_req) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else if (bus.next_pc[1:0] != 2'b00) begin
              state_q      <= StFault;
              fault_code_q <= 2'b01;
              fault_pc_q   <= bus.next_pc;
              fault_q      <= 1'b1;
            end else begin
              pc_q    <= bus.next_pc;
              state_q <= StFetch;
              req_q   <= 1'b1;
            end
          end
        end
        StHalt, StFault: ;
        default: ;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: captured instructions are scoreboarded
// at EXEC entry; status outputs are checked against bench constants.
module tb_fetch_ctrl;

  logic clk;
  logic rst;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC(32'h0000_3000),
    .TIMEOUT (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_vec;
  int       n_err;
  logic     valid_prev;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs and sample registered outputs 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on each rising edge of instr_valid.
  always @(negedge clk) begin
    if (bus.instr_valid && !valid_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        check("sb_instr", bus.instr, it.instr);
        check("sb_pc", bus.pc, it.pc);
      end
    end
    valid_prev <= bus.instr_valid;
  end

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pc  = 32'h0000_3000;
    exp_ret = 32'd0;
  endtask

  task automatic fetch(input logic [31:0] rdata, input int delay);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < delay; i++) step();
    check("req_before_ack", 32'(bus.imem_req), 32'd1);
    check("addr_before_ack", bus.imem_addr, exp_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    sb_q.push_back('{pc: exp_pc, instr: rdata});
    step();
    bus.imem_ack = 1'b0;
    check("exec_valid", 32'(bus.instr_valid), 32'd1);
    check("exec_req", 32'(bus.imem_req), 32'd0);
  endtask

  task automatic exec(input logic [31:0] npc, input logic halt);
    bus.exec_done = 1'b1;
    bus.next_pc   = npc;
    bus.halt_req  = halt;
    step();
    bus.exec_done = 1'b0;
    bus.halt_req  = 1'b0;
    exp_ret = exp_ret + 32'd1;
    if (!halt && npc[1:0] == 2'b00) exp_pc = npc;
    check("retired", bus.retired, exp_ret);
    check("pc_after_exec", bus.pc, exp_pc);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    valid_prev = 1'b0;
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.exec_done = 1'b0;
    bus.next_pc = '0;
    bus.halt_req = 1'b0;
    step();

    // Reset with a coincident ack that must be discarded.
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    do_reset();
    bus.imem_ack = 1'b0;
    check("rst_req", 32'(bus.imem_req), 32'd1);
    check("rst_addr", bus.imem_addr, 32'h0000_3000);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_retired", bus.retired, 32'd0);
    check("rst_fcode", 32'(bus.fault_code), 32'd0);
    check("rst_fpc", bus.fault_pc, 32'd0);

    // Minimum 2-cycle loop.
    fetch(32'h0000_0013, 0);
    exec(32'h0000_3004, 1'b0);
    check("loop_addr", bus.imem_addr, 32'h0000_3004);
    check("loop_req", 32'(bus.imem_req), 32'd1);

    // Delayed ack; stray ack and halt_req without exec_done while in EXEC.
    do_reset();
    fetch(32'h2402_000A, 3);
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h1111_0000 + 32'(i);
      bus.halt_req   = (i == 1);
      step();
      check("exec_hold_pc", bus.pc, 32'h0000_3000);
      check("exec_hold_instr", bus.instr, 32'h2402_000A);
      check("exec_hold_valid", 32'(bus.instr_valid), 32'd1);
      check("exec_hold_halted", 32'(bus.halted), 32'd0);
    end
    bus.imem_ack = 1'b0;
    bus.halt_req = 1'b0;
    exec(32'h0000_3008, 1'b0);

    // Stray exec_done (with halt and misaligned next_pc) during FETCH.
    bus.exec_done = 1'b1;
    bus.halt_req  = 1'b1;
    bus.next_pc   = 32'h0000_3006;
    step();
    step();
    bus.exec_done = 1'b0;
    bus.halt_req  = 1'b0;
    check("fetch_stray_pc", bus.pc, 32'h0000_3008);
    check("fetch_stray_req", 32'(bus.imem_req), 32'd1);
    check("fetch_stray_ret", bus.retired, 32'd1);
    check("fetch_stray_halt", 32'(bus.halted), 32'd0);

    // Misaligned next_pc faults without updating pc.
    do_reset();
    fetch(32'h0000_0001, 0);
    exec(32'h0000_3006, 1'b0);
    check("mis_fault", 32'(bus.fault), 32'd1);
    check("mis_code", 32'(bus.fault_code), 32'd1);
    check("mis_fpc", bus.fault_pc, 32'h0000_3006);
    check("mis_req", 32'(bus.imem_req), 32'd0);
    check("mis_valid", 32'(bus.instr_valid), 32'd0);
    bus.exec_done = 1'b1;
    bus.imem_ack  = 1'b1;
    bus.next_pc   = 32'h0000_4000;
    step();
    step();
    bus.exec_done = 1'b0;
    bus.imem_ack  = 1'b0;
    check("fault_term_pc", bus.pc, 32'h0000_3000);
    check("fault_term_code", 32'(bus.fault_code), 32'd1);
    check("fault_term_ret", bus.retired, 32'd1);

    // Halt wins over misaligned next_pc.
    do_reset();
    fetch(32'h0000_0002, 0);
    exec(32'h0000_3006, 1'b1);
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_fault", 32'(bus.fault), 32'd0);
    check("halt_req_out", 32'(bus.imem_req), 32'd0);
    check("halt_valid", 32'(bus.instr_valid), 32'd0);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("halt_term", 32'(bus.halted), 32'd1);

    // Fetch timeout after 16 request cycles.
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("to_pre_fault", 32'(bus.fault), 32'd0);
    check("to_pre_req", 32'(bus.imem_req), 32'd1);
    step();
    check("to_fault", 32'(bus.fault), 32'd1);
    check("to_code", 32'(bus.fault_code), 32'd2);
    check("to_fpc", bus.fault_pc, 32'h0000_3000);
    check("to_req", 32'(bus.imem_req), 32'd0);

    // Ack in the 16th cycle wins over the timeout.
    do_reset();
    fetch(32'h0000_00AA, 15);
    check("to_ack_fault", 32'(bus.fault), 32'd0);

    // Reset mid-EXEC.
    exec(32'h0000_3010, 1'b0);
    fetch(32'h0000_00BB, 1);
    do_reset();
    check("rst_exec_addr", bus.imem_addr, 32'h0000_3000);
    check("rst_exec_ret", bus.retired, 32'd0);
    check("rst_exec_req", 32'(bus.imem_req), 32'd1);
    check("rst_exec_valid", 32'(bus.instr_valid), 32'd0);

    // retired wraps from all-ones to zero.
    fetch(32'h0000_00CC, 0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_ret = 32'hFFFF_FFFF;
    exec(32'h0000_3020, 1'b0);
    check("wrap_fault", 32'(bus.fault), 32'd0);

    step();
    check("sb_left", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
